fpu_add_arbiter: RTL
====================

Name: fpu_add_arbiter

Overview:
- Shares one pipelined floating-point adder (fixed latency, no backpressure, arg_vld/res_vld protocol) among N requesters.
- Performs round-robin arbitration with at most one issue per cycle.
- Tracks each issued operation's requester ID in a tag pipeline matched to the adder latency, and routes each result back as an ID-tagged response.
- Sits between the FPU datapath and its clients (e.g. the vector or accumulate sequencers).

Parameters:
- N, 4: number of requesters (2..8).
- LATENCY, 7: cycles from fpu_arg_vld to fpu_res_vld; 1 input-fetch stage plus 6 adder stages.
- IDW, $clog2(N): requester ID width (localparam).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_vld  in  N  per-requester operation valid
- req_a  in  N*32  operand A; requester i occupies bits [32i+31:32i]
- req_b  in  N*32  operand B; same packing as req_a
- req_rdy  out  N  one-hot grant; handshake on req_vld[i] & req_rdy[i]
- fpu_a  out  32  operand A to adder
- fpu_b  out  32  operand B to adder
- fpu_arg_vld  out  1  issue strobe to adder
- fpu_result  in  32  adder result
- fpu_state  in  2  adder status (OK/NAN/INF/NUL)
- fpu_res_vld  in  1  adder result valid
- rsp_vld  out  1  response valid (no backpressure)
- rsp_id  out  IDW  requester that owns the response
- rsp_result  out  32  registered copy of fpu_result
- rsp_state  out  2  registered copy of fpu_state
- busy  out  1  high while any tag is in flight or fpu_arg_vld is high
- err  out  1  sticky protocol-mismatch flag

Behaviour:
- Reset: all registered outputs are 0 (fpu_a, fpu_b, fpu_arg_vld, rsp_*, err). Tag pipeline is cleared. Round-robin pointer ptr=0. req_rdy is 0 during rst.
- Arbitration (combinational):
  - Search req_vld starting at index ptr, wrapping modulo N. The first set bit gets req_rdy.
  - req_rdy is all zero when req_vld is all zero.
  - req_rdy never depends on adder state, because the adder always accepts.
- Pointer update: on a handshake by requester g, the next ptr = (g+1) mod N. If there is no handshake, ptr holds. With N=4, requester 3 wraps the pointer to 0.
- Issue: the cycle after handshake at cycle t (i.e. at t+1), fpu_arg_vld=1 and fpu_a/fpu_b hold the granted operands. Otherwise fpu_arg_vld=0 and fpu_a/fpu_b hold their last values.
- Requester rule: while req_vld[i]=1 and it is not yet granted, the requester holds req_a/req_b stable. The arbiter does not check this.
- Tag pipeline: LATENCY-deep shift register of {vld, id}.
  - Loaded at the same edge fpu_arg_vld is asserted.
  - Advances every cycle.
  - Its output is the expected-tag for the cycle in which fpu_res_vld should arrive.
- Response:
  - When fpu_res_vld=1 and the expected-tag vld=1, the next cycle drives rsp_vld=1, rsp_id=tag id, and rsp_result/rsp_state = fpu_result/fpu_state.
  - Otherwise rsp_vld=0 and the data fields hold.
  - End-to-end latency: handshake at cycle t gives rsp_vld at t+LATENCY+2.
- Throughput: one op per cycle. Back-to-back grants to different requesters produce back-to-back responses in grant order.
- Mismatch: fpu_res_vld differs from expected-tag vld in any cycle → err<=1 (sticky until rst).
  - Unexpected result (fpu_res_vld=1, tag vld=0) is dropped, rsp_vld=0.
  - Missing result (tag vld=1, fpu_res_vld=0) produces no response.
- busy = fpu_arg_vld | OR of all tag vld bits.
- Reset mid-operation: in-flight tags are discarded and no response is emitted for them. Adder results arriving after rst deassertion while tags are empty set err.

Decomposition:
- Package fpu_arb_pkg holds:
  - state codes OK=2'b00, NAN=2'b01, INF=2'b10, NUL=2'b11;
  - a tag typedef (vld + id);
  - a response typedef (id, result, state).
- Sub-module rr_arbiter (parameter N) holds the pointer register and rotate-priority-unrotate grant logic. It outputs a one-hot grant and a binary grant index.
- Tag pipeline and response register stay in the top module.

Test Plan:
1. Single op: requester 2 issues a=0x3F800000, b=0x40000000 at cycle 5 → fpu_arg_vld at 6; model returns 0x40400000/OK at 13; rsp_vld at 14 with id=2, result 0x40400000, rsp_state=00; busy low from 14.
2. All four req_vld held high for 8 cycles starting from ptr=0 → grants 0,1,2,3,0,1,2,3 on consecutive cycles; responses arrive in that id order on 8 consecutive cycles.
3. Wrap and fairness: after a grant to 3, req_vld=4'b1001 → grant 0, then 3, then 0, alternating.
4. Status passthrough: a=0x7F800000, b=0x3F800000 with model returning INF → rsp_state=2'b10 with the correct id.
5. Protocol error: inject fpu_res_vld=1 with no op in flight → err=1, rsp_vld stays 0; err stays 1 until rst.
6. Reset mid-flight: issue 3 ops, assert rst for 1 cycle two cycles later → no rsp_vld for them, busy=0 next cycle, ptr=0, first post-reset request from 1 and 3 grants 1.

Source files
------------

// File: rtl/fpu_add_arbiter_pkg.sv
// Shared types for the FPU adder arbiter: adder status codes, tag and response records.
package fpu_arb_pkg;

    localparam int ID_W = 3;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_NAN = 2'b01,
        ST_INF = 2'b10,
        ST_NUL = 2'b11
    } fpu_state_e;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     result;
        fpu_state_e      state;
    } rsp_t;

endpackage

// File: rtl/fpu_add_arbiter_if.sv
// Requester, adder and response signals of the arbiter; slave is the arbiter side.
interface fpu_add_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]    req_vld;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_rdy;
    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    logic            fpu_arg_vld;
    logic [31:0]     fpu_result;
    logic [1:0]      fpu_state;
    logic            fpu_res_vld;
    logic            rsp_vld;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_result;
    logic [1:0]      rsp_state;
    logic            busy;
    logic            err;

    modport slave (
        input  req_vld, req_a, req_b, fpu_result, fpu_state, fpu_res_vld,
        output req_rdy, fpu_a, fpu_b, fpu_arg_vld, rsp_vld, rsp_id, rsp_result, rsp_state,
               busy, err
    );

    modport master (
        output req_vld, req_a, req_b, fpu_result, fpu_state, fpu_res_vld,
        input  req_rdy, fpu_a, fpu_b, fpu_arg_vld, rsp_vld, rsp_id, rsp_result, rsp_state,
               busy, err
    );

endinterface

// File: rtl/fpu_add_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotate requests by the pointer, pick the lowest, unrotate to an index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_vld
);

    logic [IDW-1:0] ptr;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;

    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N-1:0];
        gnt_vld = 1'b0;
        off     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_vld = 1'b1;
                off     = IDW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
        gnt_idx = sum[IDW-1:0];
        // No grant while in reset, so nothing can handshake into a clearing pipeline.
        if (rst) gnt_vld = 1'b0;
        gnt = gnt_vld ? (N'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one fixed-latency pipelined adder among N requesters and returns ID-tagged results.
module fpu_add_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int LATENCY = 7
) (
    input logic clk,
    input logic rst,
    fpu_add_arbiter_if.slave bus
);

    localparam int IDW = $clog2(N);

    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_vld;
    logic [31:0]    sel_a, sel_b;
    logic [31:0]    fpu_a_q, fpu_b_q;
    logic           arg_vld_q;
    rsp_t           rsp_q;
    logic           rsp_vld_q;
    logic           err_q;
    logic           busy_c;
    tag_t           exp_tag;
    // Stage 0 is loaded alongside fpu_arg_vld; stage LATENCY lines up with fpu_res_vld.
    tag_t           tag_q [LATENCY+1];

    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_vld),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_a = bus.req_a[i*32 +: 32];
                sel_b = bus.req_b[i*32 +: 32];
            end
        end
    end

    assign exp_tag = tag_q[LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            arg_vld_q <= 1'b0;
            fpu_a_q   <= '0;
            fpu_b_q   <= '0;
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
        end else begin
            arg_vld_q <= gnt_vld;
            if (gnt_vld) begin
                fpu_a_q <= sel_a;
                fpu_b_q <= sel_b;
            end
            tag_q[0] <= '{vld: gnt_vld, id: ID_W'(gnt_idx)};
            for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
            rsp_vld_q <= bus.fpu_res_vld & exp_tag.vld;
            if (bus.fpu_res_vld && exp_tag.vld) begin
                rsp_q <= '{id: exp_tag.id, result: bus.fpu_result,
                           state: fpu_state_e'(bus.fpu_state)};
            end
            if (bus.fpu_res_vld != exp_tag.vld) err_q <= 1'b1;
        end
    end

    always_comb begin
        busy_c = arg_vld_q;
        for (int i = 0; i <= LATENCY; i++) busy_c = busy_c | tag_q[i].vld;
    end

    assign bus.req_rdy     = gnt;
    assign bus.fpu_a       = fpu_a_q;
    assign bus.fpu_b       = fpu_b_q;
    assign bus.fpu_arg_vld = arg_vld_q;
    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_id      = rsp_q.id[IDW-1:0];
    assign bus.rsp_result  = rsp_q.result;
    assign bus.rsp_state   = rsp_q.state;
    assign bus.busy        = busy_c;
    assign bus.err         = err_q;

endmodule
